// File: rtl/square_recon.sv
// Rebuilds D = Q*Q + R from a square root Q and remainder R with a radix-2 shift-add multiplier.
// Optional self-check against an expected value when SQUARE_CHECK_EN is defined.
module square_recon #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   root,
   input  logic [WIDTH:0]     rem,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] D_out,
   output logic               rem_err
`ifdef SQUARE_CHECK_EN
   ,
   input  logic [2*WIDTH-1:0] exp_val,
   output logic               mismatch
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MULT, ADD, FIN} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_root;
   logic [WIDTH-1:0]     r_mplr;
   logic [WIDTH:0]       r_rem;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_dout;
   logic                 r_err;
   logic                 w_accept;
   logic                 w_rem_err;
`ifdef SQUARE_CHECK_EN
   logic [2*WIDTH-1:0]   r_exp;
   logic                 r_mismatch;
`endif

   assign w_accept  = (r_state == IDLE) && start;
   // Both sides widened to WIDTH+2 bits so 2*Q never wraps
   assign w_rem_err = ({1'b0, r_rem} > {1'b0, r_root, 1'b0});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = MULT;
         MULT:    if (r_cnt == CW'(1)) w_next = ADD;
         ADD:     w_next = FIN;
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_root  <= '0;
         r_mplr  <= '0;
         r_rem   <= '0;
         r_mcand <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_dout  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_root  <= root;
            r_mplr  <= root;
            r_rem   <= rem;
            r_mcand <= {{WIDTH{1'b0}}, root};
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
         end else begin
            case (r_state)
               MULT: begin
                  if (r_mplr[0]) r_acc <= r_acc + r_mcand;
                  r_mcand <= r_mcand << 1;
                  r_mplr  <= r_mplr >> 1;
                  r_cnt   <= r_cnt - CW'(1);
               end
               ADD: r_acc <= r_acc + {{(WIDTH-1){1'b0}}, r_rem};
               FIN: begin
                  r_dout <= r_acc;
                  r_err  <= w_rem_err;
                  r_done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SQUARE_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp      <= '0;
         r_mismatch <= 1'b0;
      end else begin
         if (w_accept)         r_exp      <= exp_val;
         if (r_state == FIN)   r_mismatch <= (r_acc != r_exp);
      end
   end
   assign mismatch = r_mismatch;
`endif

   assign busy    = (r_state != IDLE);
   assign done    = r_done;
   assign D_out   = r_dout;
   assign rem_err = r_err;

endmodule

// File: tb/tb_square_recon.sv
// Scoreboard bench for square_recon: expected D/rem_err queued at start, popped on done.
module tb_square_recon;
   localparam int W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [W-1:0]     root = '0;
   logic [W:0]       rem = '0;
   logic             busy;
   logic             done;
   logic [2*W-1:0]   D_out;
   logic             rem_err;

   typedef struct packed {
      logic [2*W-1:0] d;
      logic           err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   square_recon #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .root(root), .rem(rem),
      .busy(busy), .done(done), .D_out(D_out), .rem_err(rem_err)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] q, input logic [W:0] r);
      logic [63:0] full;
      exp_t e;
      full  = 64'(q) * 64'(q) + 64'(r);
      e.d   = full[2*W-1:0];
      e.err = (64'(r) > 64'(q) * 64'd2);
      return e;
   endfunction

   // Drive a request (called before an edge) and step past the accepting edge E0.
   task automatic launch(input logic [W-1:0] q, input logic [W:0] r);
      root  = q;
      rem   = r;
      start = 1'b1;
      sb.push_back(model(q, r));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wait for done; optionally pulse start with junk at cycle glitch_at while busy.
   task automatic await_done(input string name, input int glitch_at);
      int   k;
      bit   busy_ok;
      exp_t e;
      k = 0;
      busy_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (done || k >= 40) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (k == glitch_at) begin
            start = 1'b1;
            root  = W'($urandom);
            rem   = (W+1)'($urandom);
         end else if (k == glitch_at + 1) begin
            start = 1'b0;
         end
         k++;
      end
      n_cmp++;
      if (k != 18) begin
         n_bad++;
         $display("FAIL %s latency: got %0d cycles, want 18", name, k);
      end
      n_cmp++;
      if (!busy_ok) begin
         n_bad++;
         $display("FAIL %s busy: dropped before done", name);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s busy_in_done: got %b, want 0", name, busy);
      end
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s scoreboard: empty on done", name);
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if (D_out !== e.d) begin
            n_bad++;
            $display("FAIL %s D_out: got %h, want %h", name, D_out, e.d);
         end
         n_cmp++;
         if (rem_err !== e.err) begin
            n_bad++;
            $display("FAIL %s rem_err: got %b, want %b", name, rem_err, e.err);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({busy, done, rem_err} !== 3'b000 || D_out !== '0) begin
         n_bad++;
         $display("FAIL reset: got busy=%b done=%b rem_err=%b D_out=%h, want all 0",
                  busy, done, rem_err, D_out);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_zero();
      @(negedge clk);
      launch(16'd0, 17'd0);
      await_done("zero", -1);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      launch(16'd255, 17'd0);
      await_done("b2b_first", -1);
      launch(16'd100, 17'd5);
      await_done("b2b_second", -1);
   endtask

   task automatic test_hold();
      logic [2*W-1:0] held;
      held = D_out;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_done: got %b, want 0", done);
      end
      n_cmp++;
      if (D_out !== 32'h0000_2715 || D_out !== held) begin
         n_bad++;
         $display("FAIL hold_D_out: got %h, want 00002715", D_out);
      end
   endtask

   task automatic test_boundary();
      @(negedge clk);
      launch(16'hFFFF, 17'h1FFFE);
      await_done("max_legal", -1);
      @(negedge clk);
      launch(16'd3, 17'd7);
      await_done("illegal_rem", -1);
      @(negedge clk);
      launch(16'hFFFF, 17'h1FFFF);
      await_done("max_illegal", -1);
   endtask

   task automatic test_busy_ignore();
      @(negedge clk);
      launch(16'd10, 17'd1);
      await_done("busy_ignore", 3);
   endtask

   task automatic test_random();
      logic [W-1:0] q;
      logic [W:0]   r;
      for (int i = 0; i < 6; i++) begin
         q = W'($urandom);
         r = (W+1)'($urandom_range(0, 2 * int'(q)));
         @(negedge clk);
         launch(q, r);
         await_done("random", (i == 2) ? 9 : -1);
      end
   endtask

   task automatic test_reset_abort();
      int dones;
      @(negedge clk);
      launch(16'd77, 17'd3);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start = (k == 5);
         if (k == 5) begin
            root = 16'd9;
            rem  = 17'd1;
         end
      end
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, rem_err} !== 3'b000 || D_out !== '0) begin
         n_bad++;
         $display("FAIL abort_reset: got busy=%b done=%b rem_err=%b D_out=%h, want all 0",
                  busy, done, rem_err, D_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) dones++;
      end
      n_cmp++;
      if (dones != 0) begin
         n_bad++;
         $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
      end
      sb.delete();
      launch(16'd2, 17'd1);
      await_done("after_abort", -1);
   endtask

   initial begin
      test_reset();
      test_zero();
      test_back_to_back();
      test_hold();
      test_boundary();
      test_busy_ignore();
      test_random();
      test_reset_abort();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
